// File: rtl/gearbox_pkg.sv
// gearbox_pkg: shared widths, idle block and sync header codes for the 66b/40b gearboxes
//   GB_BLOCK_W / GB_WORD_W / GB_FILL_W : block, word and fill-counter widths
//   GB_STOR_W  : residue register width (a block minus one bit is the most ever held)
//   GB_COMB_W  : merge network width (39 residual bits + one 66-bit block)
//   GB_IDLE_BLOCK : control block, sync 2'b01, block type 0x1E, all other bits zero
package gearbox_pkg;
   localparam int GB_BLOCK_W = 66;
   localparam int GB_WORD_W  = 40;
   localparam int GB_FILL_W  = 7;
   localparam int GB_STOR_W  = GB_BLOCK_W - 1;
   localparam int GB_COMB_W  = GB_WORD_W - 1 + GB_BLOCK_W;
   localparam logic [1:0] SH_DATA = 2'b10;
   localparam logic [1:0] SH_CTRL = 2'b01;
   localparam logic [GB_BLOCK_W-1:0] GB_IDLE_BLOCK = {56'd0, 8'h1E, SH_CTRL};
   function automatic logic hdr_ok(input logic [1:0] sh);
      return (sh == SH_DATA) || (sh == SH_CTRL);
   endfunction
endpackage

// File: rtl/gearbox_66_40.sv
// gearbox_66_40: transmit gearbox, 66-bit blocks in, continuous 40-bit words out (lsbit first)
//   clk, rst_n   : clock, asynchronous active-low reset
//   din          : 66-bit block, sync header in [1:0], bit 0 sent first
//   din_valid    : din holds a block
//   din_ready    : a block is consumed this cycle if din_valid (fill < 40)
//   dout         : 40-bit output word, bit 0 first on the wire
//   dout_valid   : dout carries stream data (high from first accepted block until reset)
//   underflow    : one-cycle pulse, a block was needed but none offered; idle block sent
//   fill_level   : residual bits held after this cycle's output
//   bad_header   : (GEARBOX_66_40_HDR_CHECK_EN only) pulse on an accepted block with
//                  sync header 00/11; that block is replaced by the idle block
module gearbox_66_40
   import gearbox_pkg::*;
#(
   parameter logic [GB_BLOCK_W-1:0] IDLE_BLOCK = GB_IDLE_BLOCK,
   parameter int                    RESET_FILL = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [GB_BLOCK_W-1:0] din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [GB_WORD_W-1:0]  dout,
   output logic                  dout_valid,
   output logic                  underflow,
`ifdef GEARBOX_66_40_HDR_CHECK_EN
   output logic                  bad_header,
`endif
   output logic [GB_FILL_W-1:0]  fill_level
);
   localparam logic [GB_FILL_W-1:0] FILL0  = GB_FILL_W'(RESET_FILL);
   localparam logic [GB_FILL_W-1:0] WORD_N = GB_FILL_W'(GB_WORD_W);
   localparam logic [GB_FILL_W-1:0] STEP   = GB_FILL_W'(GB_BLOCK_W - GB_WORD_W);

   logic [GB_STOR_W-1:0]  stor;
   logic [GB_FILL_W-1:0]  fill;
   logic                  started;
   logic                  need;
   logic                  take;
   logic                  hdr_bad;
   logic [GB_BLOCK_W-1:0] word;
   logic [GB_COMB_W-1:0]  mask;
   logic [GB_COMB_W-1:0]  comb_v;

   assign need = fill < WORD_N;
   // before the first block arrives nothing is consumed; afterwards an idle block fills gaps
   assign take = need && (din_valid || started);
`ifdef GEARBOX_66_40_HDR_CHECK_EN
   assign hdr_bad = din_valid && !hdr_ok(din[1:0]);
`else
   assign hdr_bad = 1'b0;
`endif
   assign word = (din_valid && !hdr_bad) ? din : IDLE_BLOCK;
   // new block sits directly above the fill residual bits: {word, stor[fill-1:0]}
   assign mask   = (GB_COMB_W'(1) << fill) - GB_COMB_W'(1);
   assign comb_v = (GB_COMB_W'(word) << fill) | (GB_COMB_W'(stor) & mask);
   assign din_ready  = need;
   assign fill_level = fill;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stor       <= '0;
         fill       <= FILL0;
         started    <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         underflow  <= need && started && !din_valid;
         dout_valid <= started || (need && din_valid);
         if (take) begin
            dout    <= comb_v[GB_WORD_W-1:0];
            stor    <= comb_v[GB_COMB_W-1:GB_WORD_W];
            fill    <= fill + STEP;
            started <= 1'b1;
         end else if (!need) begin
            dout <= stor[GB_WORD_W-1:0];
            stor <= stor >> GB_WORD_W;
            fill <= fill - WORD_N;
         end
      end
   end

`ifdef GEARBOX_66_40_HDR_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bad_header <= 1'b0;
      else        bad_header <= need && hdr_bad;
   end
`endif
endmodule
